// File: rtl/ls_unit_pkg.sv
// Shared widths, opcode encodings, bus idle values and FSM state type for
// the load/store execution unit.
package ls_unit_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int OP_W   = 5;
  localparam int ADDR_W = 32;

  // Idle values driven on the LS CDB when nothing is being broadcast
  localparam logic [TAG_W-1:0]  TAG_FREE  = '0;
  localparam logic [DATA_W-1:0] DATA_FREE = '0;

  // Memory op encodings issued by the LS buffer
  localparam logic [OP_W-1:0] OP_LB  = 5'd1;
  localparam logic [OP_W-1:0] OP_LH  = 5'd2;
  localparam logic [OP_W-1:0] OP_LW  = 5'd3;
  localparam logic [OP_W-1:0] OP_LBU = 5'd4;
  localparam logic [OP_W-1:0] OP_LHU = 5'd5;
  localparam logic [OP_W-1:0] OP_SB  = 5'd6;
  localparam logic [OP_W-1:0] OP_SH  = 5'd7;
  localparam logic [OP_W-1:0] OP_SW  = 5'd8;

  // Access size encoding on memSize
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } ls_state_t;

endpackage

// File: rtl/ls_extend.sv
// Opcode decoder for the LS unit: gives access size, validity and direction,
// and shapes a 32b word. For loads the word is the sign/zero-extended read
// data; for stores it is the store data with unused upper bytes zeroed.
module ls_extend
  import ls_unit_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext_data,
  output logic [1:0]        mem_size,
  output logic              is_valid,
  output logic              is_load
);

  // Decode the opcode and shape the data word to its access size
  always_comb begin
    ext_data = '0;
    mem_size = MEM_SIZE_BYTE;
    is_valid = 1'b0;
    is_load  = 1'b0;
    case (op)
      OP_LB: begin
        ext_data = {{24{raw[7]}}, raw[7:0]};
        mem_size = MEM_SIZE_BYTE;
        is_valid = 1'b1;
        is_load  = 1'b1;
      end
      OP_LBU: begin
        ext_data = {24'd0, raw[7:0]};
        mem_size = MEM_SIZE_BYTE;
        is_valid = 1'b1;
        is_load  = 1'b1;
      end
      OP_LH: begin
        ext_data = {{16{raw[15]}}, raw[15:0]};
        mem_size = MEM_SIZE_HALF;
        is_valid = 1'b1;
        is_load  = 1'b1;
      end
      OP_LHU: begin
        ext_data = {16'd0, raw[15:0]};
        mem_size = MEM_SIZE_HALF;
        is_valid = 1'b1;
        is_load  = 1'b1;
      end
      OP_LW: begin
        ext_data = raw;
        mem_size = MEM_SIZE_WORD;
        is_valid = 1'b1;
        is_load  = 1'b1;
      end
      OP_SB: begin
        ext_data = {24'd0, raw[7:0]};
        mem_size = MEM_SIZE_BYTE;
        is_valid = 1'b1;
      end
      OP_SH: begin
        ext_data = {16'd0, raw[15:0]};
        mem_size = MEM_SIZE_HALF;
        is_valid = 1'b1;
      end
      OP_SW: begin
        ext_data = raw;
        mem_size = MEM_SIZE_WORD;
        is_valid = 1'b1;
      end
      default: begin
        ext_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// Load/store execution unit: takes one op per grant from the LS buffer,
// issues a single outstanding memory request, extends load data and
// broadcasts the result on the LS CDB with a one-cycle LSdone pulse.
module ls_unit
  import ls_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              LSworkEn,
  input  logic [DATA_W-1:0] operandO,
  input  logic [DATA_W-1:0] operandT,
  input  logic [DATA_W-1:0] imm,
  input  logic [TAG_W-1:0]  wrtTag,
  input  logic [OP_W-1:0]   opCode,
  output logic              LSreadEn,
  output logic              LSdone,
  output logic              enLSwrt,
  output logic [TAG_W-1:0]  LStag,
  output logic [DATA_W-1:0] LSdata,
  output logic              memEn,
  output logic              memWr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [1:0]        memSize,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memDone,
  input  logic [DATA_W-1:0] memRdata
);

  ls_state_t state, state_next;

  logic [OP_W-1:0]   op_q;
  logic [TAG_W-1:0]  tag_q;

  logic [OP_W-1:0]   dec_op;
  logic [DATA_W-1:0] dec_raw;
  logic [DATA_W-1:0] dec_data;
  logic [1:0]        dec_size;
  logic              dec_valid;
  logic              dec_load;

  // One decoder serves both phases: in IDLE it shapes the incoming op's
  // store data, afterwards it extends the read data of the latched op.
  assign dec_op  = (state == IDLE) ? opCode   : op_q;
  assign dec_raw = (state == IDLE) ? operandT : memRdata;

  ls_extend u_extend (
    .op       (dec_op),
    .raw      (dec_raw),
    .ext_data (dec_data),
    .mem_size (dec_size),
    .is_valid (dec_valid),
    .is_load  (dec_load)
  );

  // Refuse a grant in the same cycle one is being accepted
  assign LSreadEn = (state == IDLE) & ~LSworkEn;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: invalid opcodes skip memory and respond immediately
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (LSworkEn) state_next = dec_valid ? MEM : RESP;
      MEM:  if (memDone)  state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered memory request, latched op and CDB/done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      tag_q    <= TAG_FREE;
      LSdone   <= 1'b0;
      enLSwrt  <= 1'b0;
      LStag    <= TAG_FREE;
      LSdata   <= DATA_FREE;
      memEn    <= 1'b0;
      memWr    <= 1'b0;
      memAddr  <= '0;
      memSize  <= MEM_SIZE_BYTE;
      memWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          LSdone  <= 1'b0;
          enLSwrt <= 1'b0;
          LStag   <= TAG_FREE;
          LSdata  <= DATA_FREE;
          if (LSworkEn) begin
            op_q  <= opCode;
            tag_q <= wrtTag;
            if (dec_valid) begin
              memEn    <= 1'b1;
              memWr    <= ~dec_load;
              memAddr  <= operandO + imm;
              memSize  <= dec_size;
              memWdata <= dec_load ? '0 : dec_data;
            end else begin
              LSdone <= 1'b1;
            end
          end
        end
        MEM: begin
          if (memDone) begin
            memEn  <= 1'b0;
            LSdone <= 1'b1;
            if (dec_load && (tag_q != TAG_FREE)) begin
              enLSwrt <= 1'b1;
              LStag   <= tag_q;
              LSdata  <= dec_data;
            end
          end
        end
        RESP: begin
          LSdone  <= 1'b0;
          enLSwrt <= 1'b0;
          LStag   <= TAG_FREE;
          LSdata  <= DATA_FREE;
        end
        default: begin
          memEn  <= 1'b0;
          LSdone <= 1'b0;
        end
      endcase
    end
  end

endmodule
